fc_mac_seq: RTL and testbench
=============================

# fc_mac_seq

Sequencer and multiply-accumulate engine for the final fully-connected layer (480 inputs, 3 outputs). It drives `count_ful`/`count_finish` into the fully-connected weight ROM and accepts one flattened feature per cycle from the upstream feature buffer. It multiplies each feature by the three combinational weights `weight_ful1[3:1]` and accumulates per output neuron. After all 16 chunks of 30 features, it presents three saturated 16-bit class scores downstream.

## Interface
- `N_FUL`, 30: features per chunk; `count_ful` runs 1..N_FUL.
- `N_FINISH`, 16: chunks per inference; `count_finish` runs 1..N_FINISH.
- `FRAC_BITS`, 8: fractional bits of features and weights (Q7.8).
- `ACC_W`, 48: signed accumulator width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin an inference; sampled only in IDLE.
- `feat_valid`  in  1  `feat_data` valid.
- `feat_data`  in  16 signed  feature for the current `(count_finish, count_ful)`.
- `feat_ready`  out  1  high in RUN only.
- `weight_ful1[3:1]`  in  16 signed each  combinational ROM weights for the current counters.
- `count_ful`  out  5  ROM index within chunk; 0 when not in RUN.
- `count_finish`  out  5  chunk index; 0 when not in RUN.
- `out_valid`  out  1  `fc_out` valid.
- `out_ready`  in  1  downstream accepts `fc_out`.
- `fc_out[3:1]`  out  16 signed each  class scores.
- `busy`  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE. Reset clears the counters, `acc[3:1]`, `feat_ready`, `out_valid` and `busy`; `fc_out` reads 0.
- IDLE: `count_ful = 0`, so the ROM returns zero weights. When `start` is high, the block clears `acc[1..3]`, loads `count_ful = 1` and `count_finish = 1`, and moves to RUN.
- RUN: `feat_ready = 1`. A feature is accepted when `feat_valid && feat_ready`.
  - On accept: `acc[i] <= acc[i] + feat_data * weight_ful1[i]` for i = 1..3. The 32-bit signed product is sign-extended to ACC_W.
  - Counter advance: `count_ful` increments. At `count_ful == N_FUL` it wraps to 1 and `count_finish` increments.
- Accepting feature (`N_FINISH`, `N_FUL`) moves RUN to DONE. The counters return to 0 on the same edge.
- `feat_valid` low in RUN: counters and accumulators hold. Weights stay stable because the counters are unchanged.
- DONE: `out_valid = 1`.
  - `fc_out[i] = sat16(acc[i] >>> FRAC_BITS)`, an arithmetic (floor) shift.
  - Saturation clamps to +32767 and -32768.
  - `fc_out` is stable while `out_valid && !out_ready`.
  - `out_ready` high moves DONE to IDLE.
- `start` outside IDLE is ignored. `feat_valid` outside RUN is ignored and `feat_ready` stays low.
- Worst case magnitude: 480 × 2^30 < 2^39, so ACC_W=48 cannot overflow.

## Timing
- Counters are registered; the ROM weights are valid in the same cycle as the counters. The MAC is a single-cycle registered update, with no pipeline bubble.
- `start` sampled at edge 0 puts `count_ful = 1` in cycle 1.
- Zero-stall throughput is one feature per cycle; the 480th accept occurs at edge 480.
- `out_valid` rises the cycle after the last accept (cycle 481 with no stalls).
- Minimum start-to-start period: 482 cycles, with `out_ready` held high.
- Asserting `rst` mid-RUN or mid-DONE forces IDLE immediately. Partial accumulations are discarded, and `out_valid` drops without waiting for a clock.

## Test plan
- Reset/idle: assert `rst`, release, idle 10 cycles.
  - Required: all outputs 0, `feat_ready = 0`.
  - `feat_valid` pulses cause no counter change.
- Counter sweep: start, then `feat_valid` held high.
  - Required: `count_ful` runs 1..30 sixteen times and `count_finish` runs 1..16.
  - `out_valid` is high at cycle 481; the counters read 0 in DONE.
- Single-tap arithmetic: ROM model with w1 = -768, w2 = 256, w3 = 32767. One feature = 512 at (count_finish 2, count_ful 5); all other features 0.
  - Required: `fc_out[1] = -1536`, `fc_out[2] = 512`, `fc_out[3] = 32767` (saturated from 65534).
- Saturation/negative floor: all features 256, all weights 256, giving +32767. Then all weights -1 with one feature 1, giving -1 (floor of -1/256).
- Stalls and back-pressure: random `feat_valid` duty of 30%.
  - Required: the same sums as the no-stall run.
  - With `out_ready` low for 20 cycles, `out_valid` and `fc_out` hold; one `out_ready` cycle returns the block to IDLE.
- Reset mid-run: assert `rst` after 200 accepts, then restart.
  - Required: the new result equals a clean run; `start` pulses during RUN have no effect.

Source files
------------

// File: rtl/fc_mac_seq.sv
// fc_mac_seq: sequencer and three-neuron multiply-accumulate engine for the final fully-connected layer
module fc_mac_seq #(
    parameter int N_FUL     = 30,
    parameter int N_FINISH  = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               feat_valid,
    input  logic signed [15:0] feat_data,
    output logic               feat_ready,
    input  logic signed [15:0] weight_ful1 [3:1],
    output logic        [4:0]  count_ful,
    output logic        [4:0]  count_finish,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] fc_out [3:1],
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0] FUL_LAST = 5'(N_FUL);
    localparam logic [4:0] FIN_LAST = 5'(N_FINISH);
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-32768);

    state_t                   state_q, state_d;
    logic        [4:0]        ful_q, ful_d, fin_q, fin_d;
    logic signed [ACC_W-1:0]  acc_q [3:1];
    logic signed [ACC_W-1:0]  acc_d [3:1];
    logic signed [31:0]       prod  [3:1];
    logic signed [ACC_W-1:0]  shr   [3:1];

    assign feat_ready   = state_q == RUN;
    assign out_valid    = state_q == DONE;
    assign busy         = state_q != IDLE;
    assign count_ful    = ful_q;
    assign count_finish = fin_q;

    // Class scores: floor-shift the accumulators out of Q.8 and clamp to 16 bits
    always_comb begin
        for (int i = 1; i <= 3; i++) begin
            shr[i]    = acc_q[i] >>> FRAC_BITS;
            fc_out[i] = shr[i] > MAX_V ? 16'sh7fff : shr[i] < MIN_V ? 16'sh8000 : shr[i][15:0];
        end
    end

    // Next state: start clears the sums, each accepted feature advances the ROM index and accumulates
    always_comb begin
        state_d = state_q;
        ful_d   = ful_q;
        fin_d   = fin_q;
        acc_d   = acc_q;
        for (int i = 1; i <= 3; i++) prod[i] = feat_data * weight_ful1[i];
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                ful_d   = 5'd1;
                fin_d   = 5'd1;
                acc_d   = '{default: '0};
            end
            RUN: if (feat_valid) begin
                for (int i = 1; i <= 3; i++)
                    acc_d[i] = acc_q[i] + {{(ACC_W-32){prod[i][31]}}, prod[i]};
                if (ful_q == FUL_LAST && fin_q == FIN_LAST) begin
                    state_d = DONE;
                    ful_d   = 5'd0;
                    fin_d   = 5'd0;
                end else if (ful_q == FUL_LAST) begin
                    ful_d = 5'd1;
                    fin_d = fin_q + 5'd1;
                end else begin
                    ful_d = ful_q + 5'd1;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State, counters and accumulators; reset discards any partial inference at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ful_q   <= '0;
            fin_q   <= '0;
            acc_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            ful_q   <= ful_d;
            fin_q   <= fin_d;
            acc_q   <= acc_d;
        end
    end
endmodule

// File: tb/tb_fc_mac_seq.sv
// tb_fc_mac_seq: randomized self-checking bench for fc_mac_seq against an arithmetic sum-of-products model
module tb_fc_mac_seq;
    logic               clk = 0;
    logic               rst = 1;
    logic               start = 0;
    logic               feat_valid = 0;
    logic signed [15:0] feat_data;
    logic               feat_ready;
    logic signed [15:0] weight_ful1 [3:1];
    logic        [4:0]  count_ful, count_finish;
    logic               out_valid;
    logic               out_ready = 0;
    logic signed [15:0] fc_out [3:1];
    logic               busy;

    int passed = 0;
    int total  = 0;

    logic signed [15:0] f_tab [1:16][1:30];
    logic signed [15:0] w_tab [1:3][1:16][1:30];

    fc_mac_seq dut (
        .clk(clk), .rst(rst), .start(start), .feat_valid(feat_valid), .feat_data(feat_data),
        .feat_ready(feat_ready), .weight_ful1(weight_ful1), .count_ful(count_ful),
        .count_finish(count_finish), .out_valid(out_valid), .out_ready(out_ready),
        .fc_out(fc_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Upstream feature buffer and weight ROM, both addressed by the DUT counters
    always_comb begin
        feat_data = '0;
        for (int i = 1; i <= 3; i++) weight_ful1[i] = '0;
        if (count_ful >= 1 && count_ful <= 30 && count_finish >= 1 && count_finish <= 16) begin
            feat_data = f_tab[count_finish][count_ful];
            for (int i = 1; i <= 3; i++) weight_ful1[i] = w_tab[i][count_finish][count_ful];
        end
    end

    function automatic logic signed [15:0] model(input int n);
        longint s = 0;
        for (int c = 1; c <= 16; c++)
            for (int f = 1; f <= 30; f++)
                s += longint'(f_tab[c][f]) * longint'(w_tab[n][c][f]);
        s = s >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    task automatic fill(input int fr, input int wr);
        for (int c = 1; c <= 16; c++)
            for (int f = 1; f <= 30; f++) begin
                f_tab[c][f] = 16'(int'($urandom_range(0, 2*fr)) - fr);
                for (int i = 1; i <= 3; i++) w_tab[i][c][f] = 16'(int'($urandom_range(0, 2*wr)) - wr);
            end
    endtask

    task automatic fill_const(input int fv, input int w1, input int w2, input int w3);
        for (int c = 1; c <= 16; c++)
            for (int f = 1; f <= 30; f++) begin
                f_tab[c][f]    = 16'(fv);
                w_tab[1][c][f] = 16'(w1);
                w_tab[2][c][f] = 16'(w2);
                w_tab[3][c][f] = 16'(w3);
            end
    endtask

    // Stimulus driver: pulse start, feed features at the given duty until out_valid or budget runs out
    task automatic feed_run(input int duty, input bit noise, output int cyc, output bit ok);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        cyc = 1;
        ok  = 0;
        for (int n = 0; n < 6000; n++) begin
            if (out_valid) begin ok = 1; break; end
            feat_valid = $urandom_range(0, 99) < duty;
            start      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk); cyc++;
        end
        feat_valid = 0;
        start      = 0;
    endtask

    task automatic release_done();
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        total++; if (feat_ready !== 0) $display("FAIL reset_feat_ready got %0b want 0", feat_ready); else passed++;
        total++; if (out_valid !== 0 || busy !== 0) $display("FAIL reset_flags got ov=%0b busy=%0b want 0 0", out_valid, busy); else passed++;
        total++; if (count_ful !== 0 || count_finish !== 0) $display("FAIL reset_counters got %0d/%0d want 0/0", count_finish, count_ful); else passed++;
        total++; if (fc_out[1] !== 0 || fc_out[2] !== 0 || fc_out[3] !== 0) $display("FAIL reset_fc_out got %0d %0d %0d want 0 0 0", fc_out[1], fc_out[2], fc_out[3]); else passed++;
        for (int k = 0; k < 10; k++) begin
            feat_valid = k[0];
            @(negedge clk);
            if (count_ful !== 0 || count_finish !== 0 || busy !== 0 || feat_ready !== 0) bad++;
        end
        feat_valid = 0;
        total++; if (bad !== 0) $display("FAIL idle_feat_valid got %0d bad cycles want 0", bad); else passed++;
    endtask

    task automatic test_counter_sweep();
        int bad = 0;
        fill(256, 64);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int k = 1; k <= 480; k++) begin
            if (count_ful !== 5'(((k-1) % 30) + 1) || count_finish !== 5'(((k-1) / 30) + 1) || out_valid !== 0 || feat_ready !== 1) begin
                if (bad == 0) $display("FAIL sweep_counters cycle %0d got %0d/%0d want %0d/%0d", k, count_finish, count_ful, ((k-1)/30)+1, ((k-1)%30)+1);
                bad++;
            end
            feat_valid = 1;
            @(negedge clk);
        end
        feat_valid = 0;
        total++; if (bad !== 0) $display("FAIL sweep_total got %0d bad cycles want 0", bad); else passed++;
        total++; if (out_valid !== 1 || busy !== 1 || feat_ready !== 0) $display("FAIL sweep_done_481 got ov=%0b busy=%0b rdy=%0b want 1 1 0", out_valid, busy, feat_ready); else passed++;
        total++; if (count_ful !== 0 || count_finish !== 0) $display("FAIL sweep_done_counters got %0d/%0d want 0/0", count_finish, count_ful); else passed++;
        for (int i = 1; i <= 3; i++) begin
            total++; if (fc_out[i] !== model(i)) $display("FAIL sweep_fc_out%0d got %0d want %0d", i, fc_out[i], model(i)); else passed++;
        end
        release_done();
        total++; if (out_valid !== 0 || busy !== 0) $display("FAIL sweep_release got ov=%0b busy=%0b want 0 0", out_valid, busy); else passed++;
    endtask

    task automatic test_single_tap();
        int cyc; bit ok;
        fill_const(0, -768, 256, 32767);
        f_tab[2][5] = 16'sd512;
        feed_run(100, 0, cyc, ok);
        total++; if (!ok || cyc !== 481) $display("FAIL tap_latency got ok=%0b cycle %0d want 1 481", ok, cyc); else passed++;
        total++; if (fc_out[1] !== -16'sd1536) $display("FAIL tap_out1 got %0d want -1536", fc_out[1]); else passed++;
        total++; if (fc_out[2] !== 16'sd512) $display("FAIL tap_out2 got %0d want 512", fc_out[2]); else passed++;
        total++; if (fc_out[3] !== 16'sd32767) $display("FAIL tap_out3 got %0d want 32767", fc_out[3]); else passed++;
        release_done();
    endtask

    task automatic test_saturation();
        int cyc; bit ok;
        fill_const(256, 256, 256, -256);
        feed_run(100, 0, cyc, ok);
        total++; if (!ok || fc_out[1] !== 16'sd32767 || fc_out[2] !== 16'sd32767) $display("FAIL sat_pos got %0d %0d want 32767", fc_out[1], fc_out[2]); else passed++;
        total++; if (fc_out[3] !== -16'sd32768) $display("FAIL sat_neg got %0d want -32768", fc_out[3]); else passed++;
        release_done();
        fill_const(0, -1, -1, -1);
        f_tab[16][30] = 16'sd1;
        feed_run(100, 0, cyc, ok);
        for (int i = 1; i <= 3; i++) begin
            total++; if (!ok || fc_out[i] !== -16'sd1) $display("FAIL floor_neg%0d got %0d want -1", i, fc_out[i]); else passed++;
        end
        release_done();
    endtask

    task automatic test_stalls();
        int cyc; bit ok; int bad = 0;
        logic signed [15:0] ref_out [1:3];
        fill(256, 64);
        for (int i = 1; i <= 3; i++) ref_out[i] = model(i);
        feed_run(100, 0, cyc, ok);
        for (int i = 1; i <= 3; i++) begin
            total++; if (!ok || fc_out[i] !== ref_out[i]) $display("FAIL nostall_out%0d got %0d want %0d", i, fc_out[i], ref_out[i]); else passed++;
        end
        release_done();
        feed_run(30, 0, cyc, ok);
        total++; if (!ok || cyc <= 481) $display("FAIL stall_done got ok=%0b cycle %0d want done after 481", ok, cyc); else passed++;
        for (int i = 1; i <= 3; i++) begin
            total++; if (fc_out[i] !== ref_out[i]) $display("FAIL stall_out%0d got %0d want %0d", i, fc_out[i], ref_out[i]); else passed++;
        end
        for (int k = 0; k < 20; k++) begin
            start      = 1'($urandom_range(0, 1));
            feat_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            for (int i = 1; i <= 3; i++) if (fc_out[i] !== ref_out[i]) bad++;
            if (out_valid !== 1 || count_ful !== 0) bad++;
        end
        start = 0; feat_valid = 0;
        total++; if (bad !== 0) $display("FAIL backpressure_hold got %0d bad samples want 0", bad); else passed++;
        release_done();
        total++; if (out_valid !== 0 || busy !== 0) $display("FAIL backpressure_release got ov=%0b busy=%0b want 0 0", out_valid, busy); else passed++;
    endtask

    task automatic test_reset_mid_run();
        int acc_n = 0; int cyc; bit ok;
        fill(256, 64);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int n = 0; n < 2000 && acc_n < 200; n++) begin
            feat_valid = 1'($urandom_range(0, 1));
            start      = 1'($urandom_range(0, 1));
            if (feat_valid && feat_ready) acc_n++;
            @(negedge clk);
        end
        feat_valid = 0; start = 0;
        #2 rst = 1;
        #1;
        total++; if (busy !== 0 || feat_ready !== 0 || count_ful !== 0 || count_finish !== 0) $display("FAIL midrun_reset got busy=%0b rdy=%0b cnt=%0d/%0d want 0", busy, feat_ready, count_finish, count_ful); else passed++;
        @(negedge clk); rst = 0;
        feed_run(100, 1, cyc, ok);
        total++; if (!ok || cyc !== 481) $display("FAIL restart_latency got ok=%0b cycle %0d want 1 481", ok, cyc); else passed++;
        for (int i = 1; i <= 3; i++) begin
            total++; if (fc_out[i] !== model(i)) $display("FAIL restart_out%0d got %0d want %0d", i, fc_out[i], model(i)); else passed++;
        end
        #2 rst = 1;
        #1;
        total++; if (out_valid !== 0 || busy !== 0) $display("FAIL done_reset got ov=%0b busy=%0b want 0 0", out_valid, busy); else passed++;
        @(negedge clk); rst = 0;
    endtask

    initial begin
        test_reset();
        test_counter_sweep();
        test_single_tap();
        test_saturation();
        test_stalls();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
